// File: rtl/atm_pkg.sv
// Shared types for the ATM ledger arbiter: op codes, result codes and FSM states.
package atm_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_DEP  = 2'b01,
        OP_WDR  = 2'b10,
        OP_BAL  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_OK    = 3'd0,
        ST_ZERO  = 3'd1,
        ST_FUNDS = 3'd2,
        ST_OVF   = 3'd3,
        ST_OP    = 3'd4
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/atm_ledger_arbiter_if.sv
// Terminal-side bus of the ledger arbiter: per-terminal request fields plus shared results.
interface atm_ledger_arbiter_if #(
    parameter int N_TERM = 2,
    parameter int N_ACCT = 4,
    parameter int BAL_W  = 8
);
    localparam int AW = (N_ACCT > 1) ? $clog2(N_ACCT) : 1;

    // Handshake: a terminal raises req[t] with op/acct/amount stable; gnt[t] pulses one
    // cycle when its fields are latched, done[t] pulses one cycle later when status and
    // bal_out are valid, and the terminal drops req[t] in the cycle it sees done[t].
    logic [N_TERM-1:0]       req;
    logic [2*N_TERM-1:0]     op;
    logic [AW*N_TERM-1:0]    acct;
    logic [BAL_W*N_TERM-1:0] amount;
    logic [N_TERM-1:0]       gnt;
    logic [N_TERM-1:0]       done;
    logic [2:0]              status;
    logic [BAL_W-1:0]        bal_out;
    logic                    busy;

    modport master (output req, op, acct, amount,
                    input  gnt, done, status, bal_out, busy);
    modport slave  (input  req, op, acct, amount,
                    output gnt, done, status, bal_out, busy);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: priority starts one past the last winner and wraps around.
module rr_arbiter #(
    parameter int N_TERM = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_TERM-1:0]         req,
    input  logic                      en,
    output logic [N_TERM-1:0]         gnt,
    output logic [$clog2(N_TERM)-1:0] winner
);
    localparam int TW = $clog2(N_TERM);

    logic [TW-1:0] ptr;
    logic          found;
    int            idx;

    // Reset value makes terminal 0 the first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= TW'(N_TERM - 1);
        end else if (en && (|req)) begin
            ptr <= winner;
        end
    end

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= N_TERM; i++) begin
            idx = (int'(ptr) + i) % N_TERM;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = TW'(idx);
            end
        end
    end
endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shared account ledger: arbitrates terminals round-robin and runs each
// deposit/withdraw/balance transaction atomically over IDLE -> EXEC -> RESP.
module atm_ledger_arbiter
    import atm_pkg::*;
#(
    parameter int N_TERM   = 2,
    parameter int N_ACCT   = 4,
    parameter int BAL_W    = 8,
    parameter int INIT_BAL = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    atm_ledger_arbiter_if.slave  bus,
    output state_t               state_dbg
);
    localparam int AW = (N_ACCT > 1) ? $clog2(N_ACCT) : 1;
    localparam int TW = $clog2(N_TERM);

    state_t            state, state_next;
    logic              any_req, arb_en;
    logic [N_TERM-1:0] arb_gnt, owner;
    logic [TW-1:0]     arb_win;

    op_t               lat_op;
    logic [AW-1:0]     lat_acct;
    logic [BAL_W-1:0]  lat_amt;
    logic [BAL_W-1:0]  ledger [N_ACCT];

    status_t           status_q, ex_status;
    logic [BAL_W-1:0]  bal_q, ex_bal, cur_bal, wr_val;
    logic [BAL_W:0]    sum;
    logic              acct_ok, wr_en;

    assign any_req   = |bus.req;
    assign arb_en    = (state == S_IDLE);
    assign state_dbg = state;

    rr_arbiter #(.N_TERM(N_TERM)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req),
        .en     (arb_en),
        .gnt    (arb_gnt),
        .winner (arb_win)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.gnt    = '0;
        bus.done   = '0;
        bus.busy   = (state != S_IDLE);
        case (state)
            S_IDLE: if (any_req) state_next = S_EXEC;
            S_EXEC: begin
                bus.gnt    = owner;
                state_next = S_RESP;
            end
            S_RESP: begin
                bus.done   = owner;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Widened compare keeps the range check meaningful when N_ACCT is a power of two.
    assign acct_ok = ({1'b0, lat_acct} < (AW + 1)'(N_ACCT));
    assign cur_bal = acct_ok ? ledger[lat_acct] : '0;
    assign sum     = {1'b0, cur_bal} + {1'b0, lat_amt};

    always_comb begin
        ex_status = ST_OK;
        ex_bal    = cur_bal;
        wr_en     = 1'b0;
        wr_val    = cur_bal;
        if (lat_op == OP_NONE || !acct_ok) begin
            ex_status = ST_OP;
            ex_bal    = '0;
        end else if (lat_op != OP_BAL && lat_amt == '0) begin
            ex_status = ST_ZERO;
        end else if (lat_op == OP_DEP && sum[BAL_W]) begin
            ex_status = ST_OVF;
        end else if (lat_op == OP_WDR && lat_amt > cur_bal) begin
            ex_status = ST_FUNDS;
        end else begin
            if (lat_op == OP_DEP) begin
                wr_val = sum[BAL_W-1:0];
                wr_en  = 1'b1;
            end else if (lat_op == OP_WDR) begin
                wr_val = cur_bal - lat_amt;
                wr_en  = 1'b1;
            end
            ex_bal = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ACCT; i++) ledger[i] <= BAL_W'(INIT_BAL);
            status_q <= ST_OK;
            bal_q    <= '0;
            owner    <= '0;
            lat_op   <= OP_NONE;
            lat_acct <= '0;
            lat_amt  <= '0;
        end else begin
            if (state == S_IDLE && any_req) begin
                owner    <= arb_gnt;
                lat_op   <= op_t'(bus.op[int'(arb_win)*2 +: 2]);
                lat_acct <= bus.acct[int'(arb_win)*AW +: AW];
                lat_amt  <= bus.amount[int'(arb_win)*BAL_W +: BAL_W];
            end
            if (state == S_EXEC) begin
                status_q <= ex_status;
                bal_q    <= ex_bal;
                if (wr_en) ledger[lat_acct] <= wr_val;
            end
        end
    end

    assign bus.status  = status_q;
    assign bus.bal_out = bal_q;
endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Bench for atm_ledger_arbiter: fixed vector table, hand-written corner sequences
// and randomized multi-terminal rounds against a ledger model.
module tb_atm_ledger_arbiter;
    import atm_pkg::*;

    localparam int N_TERM   = 2;
    localparam int N_ACCT   = 4;
    localparam int BAL_W    = 8;
    localparam int INIT_BAL = 20;
    localparam int AW       = $clog2(N_ACCT);
    localparam int BAL_MAX  = (1 << BAL_W) - 1;

    logic   clk, rst;
    state_t state_dbg;
    int     n_checks, n_errors;

    atm_ledger_arbiter_if #(.N_TERM(N_TERM), .N_ACCT(N_ACCT), .BAL_W(BAL_W)) intf ();

    atm_ledger_arbiter #(
        .N_TERM(N_TERM), .N_ACCT(N_ACCT), .BAL_W(BAL_W), .INIT_BAL(INIT_BAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (intf.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         term;
        logic [1:0] op;
        int         acct;
        int         amt;
        logic [2:0] st;
        int         bal;
    } vec_t;

    vec_t vecs [13];

    // reference ledger
    int m_bal [N_ACCT];
    int m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        intf.req    = '0;
        intf.op     = '0;
        intf.acct   = '0;
        intf.amount = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < N_ACCT; a++) m_bal[a] = INIT_BAL;
        m_ptr = N_TERM - 1;
    endtask

    task automatic drive_fields(input int t, input logic [1:0] o, input int a, input int amt);
        intf.op[2*t +: 2]           = o;
        intf.acct[AW*t +: AW]       = AW'(a);
        intf.amount[BAL_W*t +: BAL_W] = BAL_W'(amt);
    endtask

    // driver: one transaction from a lone terminal; late_amt >= 0 rewrites amount after gnt
    task automatic do_txn(input int t, input logic [1:0] o, input int a, input int amt,
                          input int late_amt, input logic [2:0] exp_st, input int exp_bal);
        int k;
        logic [N_TERM-1:0] want;
        want    = '0;
        want[t] = 1'b1;
        @(negedge clk);
        drive_fields(t, o, a, amt);
        intf.req[t] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (intf.gnt == '0 && k < 8);
        chk("gnt", 32'(intf.gnt), 32'(want));
        chk("gnt_latency", 32'(k), 32'd1);
        chk("busy_exec", 32'(intf.busy), 32'd1);
        if (late_amt >= 0) intf.amount[BAL_W*t +: BAL_W] = BAL_W'(late_amt);
        @(negedge clk);
        chk("done", 32'(intf.done), 32'(want));
        chk("status", 32'(intf.status), 32'(exp_st));
        chk("bal_out", 32'(intf.bal_out), 32'(exp_bal));
        intf.req[t] = 1'b0;
    endtask

    // model of one transaction, straight from the ledger rules
    task automatic ref_exec(input int o, input int a, input int amt, output int st, output int b);
        if (o == 0 || a >= N_ACCT) begin
            st = 4; b = 0;
        end else if (o != 3 && amt == 0) begin
            st = 1; b = m_bal[a];
        end else if (o == 1 && m_bal[a] + amt > BAL_MAX) begin
            st = 3; b = m_bal[a];
        end else if (o == 2 && amt > m_bal[a]) begin
            st = 2; b = m_bal[a];
        end else begin
            if (o == 1) m_bal[a] = m_bal[a] + amt;
            if (o == 2) m_bal[a] = m_bal[a] - amt;
            st = 0; b = m_bal[a];
        end
    endtask

    initial begin
        int mask, win, k, st_e, bal_e, sel;
        int r_op [N_TERM];
        int r_acct [N_TERM];
        int r_amt [N_TERM];
        logic [N_TERM-1:0] exp_g, exp_d;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;

        vecs[0]  = '{0, OP_DEP,  1,   5, ST_OK,    25};
        vecs[1]  = '{1, OP_WDR,  2,  20, ST_OK,     0};
        vecs[2]  = '{1, OP_WDR,  2,   1, ST_FUNDS,  0};
        vecs[3]  = '{0, OP_DEP,  0, 240, ST_OVF,   20};
        vecs[4]  = '{1, OP_DEP,  0,   0, ST_ZERO,  20};
        vecs[5]  = '{0, OP_NONE, 3,   7, ST_OP,     0};
        vecs[6]  = '{1, OP_BAL,  3,   0, ST_OK,    20};
        vecs[7]  = '{0, OP_BAL,  1,   0, ST_OK,    25};
        vecs[8]  = '{1, OP_WDR,  0,  19, ST_OK,     1};
        vecs[9]  = '{0, OP_DEP,  0, 254, ST_OK,   255};
        vecs[10] = '{1, OP_DEP,  0,   1, ST_OVF,  255};
        vecs[11] = '{0, OP_BAL,  2,   0, ST_OK,     0};
        vecs[12] = '{1, OP_WDR,  2,   0, ST_ZERO,   0};

        do_reset();
        chk("rst_gnt", 32'(intf.gnt), 32'd0);
        chk("rst_done", 32'(intf.done), 32'd0);
        chk("rst_status", 32'(intf.status), 32'd0);
        chk("rst_bal_out", 32'(intf.bal_out), 32'd0);
        chk("rst_busy", 32'(intf.busy), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));

        foreach (vecs[i])
            do_txn(vecs[i].term, vecs[i].op, vecs[i].acct, vecs[i].amt, -1,
                   vecs[i].st, vecs[i].bal);

        // fairness: both terminals hold req continuously
        do_reset();
        drive_fields(0, OP_BAL, 0, 0);
        drive_fields(1, OP_BAL, 0, 0);
        intf.req = '1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            exp_g = '0;
            exp_d = '0;
            if (c % 3 == 1) exp_g[(c / 3) % 2] = 1'b1;
            if (c % 3 == 2) exp_d[(c / 3) % 2] = 1'b1;
            chk("fair_gnt", 32'(intf.gnt), 32'(exp_g));
            chk("fair_done", 32'(intf.done), 32'(exp_d));
        end
        intf.req = '0;

        // reset in the EXEC cycle aborts and reinitialises the ledger
        do_reset();
        do_txn(0, OP_DEP, 3, 5, -1, ST_OK, 25);
        @(negedge clk);
        drive_fields(0, OP_WDR, 3, 10);
        intf.req[0] = 1'b1;
        @(negedge clk);
        chk("abort_gnt", 32'(intf.gnt), 32'd1);
        rst      = 1'b1;
        intf.req = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", 32'(intf.done), 32'd0);
        chk("abort_busy", 32'(intf.busy), 32'd0);
        chk("abort_state", 32'(state_dbg), 32'(S_IDLE));
        @(negedge clk);
        chk("abort_done_late", 32'(intf.done), 32'd0);
        do_txn(1, OP_BAL, 3, 0, -1, ST_OK, 20);

        // fields latched at grant
        do_reset();
        do_txn(0, OP_DEP, 1, 5, 9, ST_OK, 25);
        do_txn(0, OP_BAL, 1, 0, -1, ST_OK, 25);

        // randomized rounds with random requester sets
        do_reset();
        for (int r = 0; r < 80; r++) begin
            @(negedge clk);
            mask = $urandom_range(1, (1 << N_TERM) - 1);
            for (int t = 0; t < N_TERM; t++) begin
                r_op[t]   = $urandom_range(0, 3);
                r_acct[t] = $urandom_range(0, N_ACCT - 1);
                sel       = $urandom_range(0, 9);
                r_amt[t]  = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(200, BAL_MAX)
                                                        : $urandom_range(1, 30);
                drive_fields(t, 2'(r_op[t]), r_acct[t], r_amt[t]);
                intf.req[t] = mask[t];
            end
            win = -1;
            for (int i = 1; i <= N_TERM; i++)
                if (win < 0 && mask[(m_ptr + i) % N_TERM]) win = (m_ptr + i) % N_TERM;
            m_ptr = win;
            ref_exec(r_op[win], r_acct[win], r_amt[win], st_e, bal_e);
            exp_g      = '0;
            exp_g[win] = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (intf.gnt == '0 && k < 8);
            chk("rnd_gnt", 32'(intf.gnt), 32'(exp_g));
            @(negedge clk);
            chk("rnd_done", 32'(intf.done), 32'(exp_g));
            chk("rnd_status", 32'(intf.status), 32'(st_e));
            chk("rnd_bal_out", 32'(intf.bal_out), 32'(bal_e));
            intf.req = '0;
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/atm_ledger_arbiter.md
Name: atm_ledger_arbiter

Overview:
Shared account-ledger controller for multiple ATM terminal FSMs. It holds N_ACCT account balances in registers and arbitrates round-robin between N_TERM terminals. Each granted transaction (deposit, withdraw or balance query) executes atomically. It replaces the per-terminal balance register, so two terminals can never race on the same account.

Parameters:
N_TERM, 2, number of requesting terminals (>=2)
N_ACCT, 4, number of ledger accounts
BAL_W, 8, balance/amount width (unsigned)
INIT_BAL, 20, balance loaded into every account at reset
AW, $clog2(N_ACCT), derived account-index width (localparam)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N_TERM  per-terminal request; held stable until that terminal's done
op  in  2*N_TERM  per-terminal op, slice t = op[2t+1:2t]: 01 deposit, 10 withdraw, 11 balance, 00 illegal
acct  in  AW*N_TERM  per-terminal account index
amount  in  BAL_W*N_TERM  per-terminal amount (ignored for balance)
gnt  out  N_TERM  one-hot, 1-cycle pulse when a request is accepted
done  out  N_TERM  one-hot, 1-cycle pulse when the result is valid
status  out  3  result code of the last transaction
bal_out  out  BAL_W  account balance after the last transaction
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state=IDLE, gnt=0, done=0, status=0, bal_out=0, busy=0, rr pointer=N_TERM-1 (terminal 0 wins first), all ledger entries=INIT_BAL.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req is high at edge E0: pick the winner by round-robin. Priority starts at pointer+1 and wraps modulo N_TERM.
  - Latch the winner's op/acct/amount, pulse gnt[winner], set pointer=winner, go to EXEC.
  - No req: stay in IDLE.
- EXEC, evaluated at edge E1, in priority order:
  - op==00 or acct>=N_ACCT: status=ERR_OP(4).
  - Deposit/withdraw with amount==0: status=ERR_ZERO(1).
  - Deposit where the sum overflows BAL_W bits (carry out): status=ERR_OVF(3).
  - Withdraw with amount>balance: status=ERR_FUNDS(2). Withdraw with amount==balance is legal and leaves 0.
  - Otherwise status=OK(0). The ledger entry is written with balance+amount or balance-amount; a balance query leaves it unchanged.
  - On any error the ledger is unchanged.
  - bal_out = resulting balance for OK, else the current unchanged balance. For ERR_OP, bal_out=0.
  - Go to RESP.
- RESP: done[winner]=1 for exactly this cycle; return to IDLE at E2.
- Output hold: status and bal_out stay valid from E1 until the next EXEC.
- Latency and throughput: gnt in the cycle after E0, done in the cycle after E1. Throughput is one transaction per 3 cycles.
- Requester rule: deassert req in the cycle done is seen. A req still high when the FSM is back in IDLE is a new transaction.
- Changes to req or fields while not in IDLE are ignored; fields are latched at grant.
- Simultaneous requests: exactly one gnt per grant, round-robin order, no starvation. With all N_TERM requesting continuously, each terminal is served once per N_TERM transactions.
- Reset mid-transaction: abort immediately, no done pulse, ledger reinitialised to INIT_BAL.
- All arithmetic is unsigned BAL_W. Overflow is detected with a BAL_W+1-bit sum; underflow is prevented by the compare.

Decomposition:
- Package atm_pkg holds:
  - op codes OP_NONE/OP_DEP/OP_WDR/OP_BAL (2-bit);
  - status codes ST_OK/ST_ZERO/ST_FUNDS/ST_OVF/ST_OP (3-bit);
  - FSM state encoding.
- Sub-module rr_arbiter:
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant, winner index;
  - combinational plus pointer register.
- Ledger storage and the EXEC datapath stay in atm_ledger_arbiter.

Test Plan:
- Deposit: term0 deposit 5 to acct1 (bal 20) -> gnt[0] next cycle, done[0] two cycles later, status=0, bal_out=25, acct1=25.
- Withdraw: term1 withdraw 20 from acct2 (bal 20) -> status=0, bal_out=0. A follow-up withdraw of 1 -> status=2, bal_out=0, ledger unchanged.
- Error codes:
  - deposit 240 to acct0 (bal 20) -> status=3, bal_out=20;
  - deposit 0 -> status=1;
  - op=00 -> status=4, bal_out=0, no ledger write.
- Fairness: term0 and term1 both hold req continuously with balance queries -> grants alternate 0,1,0,1, with terminal 0 first after reset, each spaced 3 cycles.
- Reset abort: assert rst in the EXEC cycle of a withdraw 10 from acct3 -> no done pulse, acct3 reads 20 on a subsequent balance query, busy=0 the cycle after reset.
- Field hold: term0 changes amount from 5 to 9 after gnt -> deposit uses 5 (bal_out=25); a balance query on the same account then returns 25.
